// File: rtl/mega_ram_dma_pkg.sv
// rtl/mega_ram_dma_pkg.sv - shared widths, FSM states and mode constants for the RAM DMA
// Purpose: single home for the default bus widths, the controller state encoding and the
//          copy/fill mode values used by the interface, the DMA core and the bench.
// Ports:   none (package).
package mega_ram_dma_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int LEN_W  = ADDR_W + 1;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_RD_A = 3'd2,
      S_RD_D = 3'd3,
      S_WR   = 3'd4,
      S_FIN  = 3'd5
   } state_e;

   // Where a byte transfer starts: copy reads first, fill goes straight to the write.
   function automatic state_e first_access(input logic mode);
      return (mode == MODE_COPY) ? S_RD_A : S_WR;
   endfunction

endpackage

// File: rtl/mega_ram_dma_if.sv
// rtl/mega_ram_dma_if.sv - arbiter handshake plus mega_ram port bundle
// Purpose: groups the bus request/grant pair and the mega_ram pins between the DMA
//          (master) and the arbiter/RAM side (slave).
// Signals: bus_req/bus_gnt arbiter handshake; ram_cs/ram_we/ram_re strobes;
//          ram_a address; ram_wdata to RAM d_in; ram_rdata from RAM d_out.
interface mega_ram_dma_if
   import mega_ram_dma_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
) ();

   logic          bus_req;
   logic          bus_gnt;
   logic          ram_cs;
   logic          ram_we;
   logic          ram_re;
   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport master (
      output bus_req, ram_cs, ram_we, ram_re, ram_a, ram_wdata,
      input  bus_gnt, ram_rdata
   );

   modport slave (
      input  bus_req, ram_cs, ram_we, ram_re, ram_a, ram_wdata,
      output bus_gnt, ram_rdata
   );

endinterface

// File: rtl/mega_ram_dma.sv
// rtl/mega_ram_dma.sv - block copy / block fill bus initiator for the mega_ram port
// Purpose: requests the data-RAM bus and copies (RAM->RAM) or fills a block of bytes at
//          ascending, wrapping addresses, honouring the RAM's 1-cycle read latency.
// Ports:   clk, rst (sync, active-high)
//          start_i/abort_i command strobes, mode_i (0 copy, 1 fill), src_i/dst_i bases,
//          len_i byte count, fill_data_i fill value (all sampled at an accepted start)
//          busy_o, done_o (1-cycle pulse), aborted_o (sticky until next start)
//          bus: mega_ram_dma_if.master (arbiter handshake and RAM pins)
module mega_ram_dma
   import mega_ram_dma_pkg::*;
#(
   parameter int ADDR_BUS_WIDTH = ADDR_W,
   parameter int DATA_BUS_WIDTH = DATA_W,
   parameter int LEN_WIDTH      = LEN_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic                      mode_i,
   input  logic [ADDR_BUS_WIDTH-1:0] src_i,
   input  logic [ADDR_BUS_WIDTH-1:0] dst_i,
   input  logic [LEN_WIDTH-1:0]      len_i,
   input  logic [DATA_BUS_WIDTH-1:0] fill_data_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      aborted_o,
   mega_ram_dma_if.master            bus
);

   state_e                    state_q,   state_d;
   state_e                    resume_q,  resume_d;
   logic                      mode_q,    mode_d;
   logic [ADDR_BUS_WIDTH-1:0] src_q,     src_d;
   logic [ADDR_BUS_WIDTH-1:0] dst_q,     dst_d;
   logic [LEN_WIDTH-1:0]      rem_q,     rem_d;
   logic [DATA_BUS_WIDTH-1:0] fill_q,    fill_d;
   logic [DATA_BUS_WIDTH-1:0] hold_q,    hold_d;
   logic [DATA_BUS_WIDTH-1:0] wdata_q,   wdata_d;
   logic                      aborted_q, aborted_d;

   logic                      active;
   logic [DATA_BUS_WIDTH-1:0] wr_val;

   assign active = (state_q == S_ARB) || (state_q == S_RD_A) ||
                   (state_q == S_RD_D) || (state_q == S_WR);
   assign wr_val = (mode_q == MODE_FILL) ? fill_q : hold_q;

   always_comb begin
      state_d   = state_q;
      resume_d  = resume_q;
      mode_d    = mode_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
      fill_d    = fill_q;
      hold_d    = hold_q;
      wdata_d   = wdata_q;
      aborted_d = aborted_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               mode_d    = mode_i;
               src_d     = src_i;
               dst_d     = dst_i;
               rem_d     = len_i;
               fill_d    = fill_data_i;
               aborted_d = 1'b0;
               resume_d  = first_access(mode_i);
               state_d   = (len_i == '0) ? S_FIN : S_ARB;
            end
         end
         S_ARB: begin
            if (bus.bus_gnt) state_d = resume_q;
         end
         S_RD_A, S_RD_D: begin
            // A lost grant mid-read restarts the byte: the read data pipe is not trusted.
            if (!bus.bus_gnt) begin
               state_d  = S_ARB;
               resume_d = S_RD_A;
            end else if (state_q == S_RD_A) begin
               state_d = S_RD_D;
            end else begin
               hold_d  = bus.ram_rdata;
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (!bus.bus_gnt) begin
               state_d  = S_ARB;
               resume_d = S_WR;
            end else begin
               wdata_d = wr_val;
               src_d   = src_q + ADDR_BUS_WIDTH'(1);
               dst_d   = dst_q + ADDR_BUS_WIDTH'(1);
               rem_d   = rem_q - LEN_WIDTH'(1);
               state_d = (rem_q == LEN_WIDTH'(1)) ? S_FIN : first_access(mode_q);
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort overrides the transfer but not the RAM strobes of this cycle,
      // so a write already on the bus still lands.
      if (abort_i && active) begin
         state_d   = S_FIN;
         aborted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         resume_q  <= S_RD_A;
         mode_q    <= MODE_COPY;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         fill_q    <= '0;
         hold_q    <= '0;
         wdata_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         resume_q  <= resume_d;
         mode_q    <= mode_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
         fill_q    <= fill_d;
         hold_q    <= hold_d;
         wdata_q   <= wdata_d;
         aborted_q <= aborted_d;
      end
   end

   // RAM strobes are gated by the live grant so a dropped grant has no RAM effect.
   // cs&re stay up through RD_D because mega_ram only drives d_out while cs&re.
   assign bus.bus_req   = active;
   assign bus.ram_cs    = bus.bus_gnt && ((state_q == S_RD_A) || (state_q == S_RD_D) ||
                                          (state_q == S_WR));
   assign bus.ram_re    = bus.bus_gnt && ((state_q == S_RD_A) || (state_q == S_RD_D));
   assign bus.ram_we    = bus.bus_gnt && (state_q == S_WR);
   assign bus.ram_a     = ((state_q == S_RD_A) || (state_q == S_RD_D)) ? src_q :
                          (state_q == S_WR) ? dst_q : '0;
   assign bus.ram_wdata = bus.ram_we ? wr_val : wdata_q;

   assign busy_o    = active;
   assign done_o    = (state_q == S_FIN);
   assign aborted_o = aborted_q;

endmodule
